// File: rtl/gb_serial_link_if.sv
// rtl/gb_serial_link_if.sv - CPU bus bundle for the link-port serial controller
// Purpose: groups the CPU-side register access signals.
// Signals: addr/wdata/we driven by the CPU (master); rdata/hit returned by
//          the peripheral (slave). rdata is combinational and 8'h00 when hit=0.
interface gb_serial_link_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  rdata;
  logic        hit;

  modport master (output addr, output wdata, output we, input rdata, input hit);
  modport slave  (input addr, input wdata, input we, output rdata, output hit);
endinterface

// File: rtl/gb_serial_link.sv
// rtl/gb_serial_link.sv - Game Boy link-port serial controller (SB/SC registers)
// Purpose: shifts SB out MSB-first on sout while shifting sin in, clocked by an
//          internal divider or a synchronized external shift clock; pulses
//          irq_serial for one cycle when the eighth bit has been shifted.
// Ports: clk, rst (async active-low); bus (CPU register access, slave side);
//        sclk_in/sin (external clock and serial data in);
//        sclk_out/sclk_oe/sout (shift clock, its drive enable, serial data out);
//        irq_serial (one-cycle completion pulse).
module gb_serial_link #(
  parameter int          CLK_DIV = 512,
  parameter logic [15:0] SB_ADDR = 16'hFF01,
  parameter logic [15:0] SC_ADDR = 16'hFF02
) (
  input  logic              clk,
  input  logic              rst,
  gb_serial_link_if.slave   bus,
  input  logic              sclk_in,
  input  logic              sin,
  output logic              sclk_out,
  output logic              sclk_oe,
  output logic              sout,
  output logic              irq_serial
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_M1 = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE_INT, ACTIVE_EXT} state_t;

  state_t           state;
  logic [7:0]       sb;
  logic             clksel;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic             sync1, sync2, sclk_prev;

  // The SC start bit is exactly "a transfer is in progress".
  logic start;
  assign start = (state != IDLE);

  logic sel_sb, sel_sc, sb_wr, sc_wr;
  assign sel_sb = (bus.addr == SB_ADDR);
  assign sel_sc = (bus.addr == SC_ADDR);
  assign sb_wr  = bus.we & sel_sb;
  assign sc_wr  = bus.we & sel_sc;
  assign bus.hit = sel_sb | sel_sc;

  always_comb begin
    bus.rdata = 8'h00;
    if (sel_sb)      bus.rdata = sb;
    else if (sel_sc) bus.rdata = {start, 6'b111111, clksel};
  end

  // Edge detection runs on the synchronized copy compared with its previous value.
  logic ext_rise, ext_fall;
  assign ext_rise = sync2 & ~sclk_prev;
  assign ext_fall = ~sync2 & sclk_prev;

  // Divider phases: pre-edge count HALF_M1 gives the rising edge, FULL_M1 the next low phase.
  logic int_rise, int_fall, shift_edge, done;
  assign int_rise   = (state == ACTIVE_INT) && (div == HALF_M1);
  assign int_fall   = (state == ACTIVE_INT) && (div == FULL_M1);
  assign shift_edge = int_rise | ((state == ACTIVE_EXT) & ext_rise);
  assign done       = shift_edge && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      sync1     <= sclk_in;
      sync2     <= sync1;
      sclk_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sb         <= 8'h00;
      clksel     <= 1'b0;
      div        <= '0;
      bit_cnt    <= 3'd0;
      sclk_out   <= 1'b1;
      sclk_oe    <= 1'b0;
      sout       <= 1'b1;
      irq_serial <= 1'b0;
    end else begin
      irq_serial <= 1'b0;

      // A CPU write to SB overrides the shift on the same edge.
      if (sb_wr)           sb <= bus.wdata;
      else if (shift_edge) sb <= {sb[6:0], sin};

      if (sc_wr) begin
        // SC writes take priority over the sequencer; completion still signals.
        clksel <= bus.wdata[0];
        if (done) irq_serial <= 1'b1;
        if (bus.wdata[7]) begin
          state   <= bus.wdata[0] ? ACTIVE_INT : ACTIVE_EXT;
          div     <= '0;
          bit_cnt <= 3'd0;
          if (bus.wdata[0]) begin
            // Internal mode: the start edge opens the low phase of bit 0.
            sclk_out <= 1'b0;
            sclk_oe  <= 1'b1;
            sout     <= sb[7];
          end else begin
            sclk_out <= 1'b1;
            sclk_oe  <= 1'b0;
          end
        end else begin
          state    <= IDLE;
          sclk_out <= 1'b1;
          sclk_oe  <= 1'b0;
          sout     <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            sclk_out <= 1'b1;
            sclk_oe  <= 1'b0;
            sout     <= 1'b1;
          end
          ACTIVE_INT: begin
            div <= (div == FULL_M1) ? '0 : div + DIV_W'(1);
            if (int_fall) begin
              sclk_out <= 1'b0;
              sout     <= sb[7];
            end
            if (int_rise) begin
              sclk_out <= 1'b1;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state      <= IDLE;
                sclk_oe    <= 1'b0;
                irq_serial <= 1'b1;
              end
            end
          end
          ACTIVE_EXT: begin
            if (ext_fall) sout <= sb[7];
            if (ext_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state      <= IDLE;
                irq_serial <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_serial_link.sv
// tb/tb_gb_serial_link.sv - self-checking bench for gb_serial_link
// Purpose: scoreboard of expected sout bits and per-scenario register checks.
// Ports: none (top-level bench).
module tb_gb_serial_link;

  localparam logic [15:0] SB = 16'hFF01;
  localparam logic [15:0] SC = 16'hFF02;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk_in = 1'b1;
  logic sin = 1'b1;
  logic sclk_out, sclk_oe, sout, irq_serial;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  gb_serial_link_if bus_if ();

  gb_serial_link #(.CLK_DIV(8), .SB_ADDR(16'hFF01), .SC_ADDR(16'hFF02)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if),
    .sclk_in(sclk_in),
    .sin(sin),
    .sclk_out(sclk_out),
    .sclk_oe(sclk_oe),
    .sout(sout),
    .irq_serial(irq_serial)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.we    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.we    = 1'b0;
    bus_if.addr  = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    bus_if.addr = a;
    #1;
    d = bus_if.rdata;
    bus_if.addr = 16'h0000;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    bus_if.we = 1'b0; bus_if.addr = 16'h0000; bus_if.wdata = 8'h00;
    rst = 1'b0;
    step(); step();
    bus_read(SC, rd);
    checks++; if (rd !== 8'h7E) begin failures++; $display("FAIL reset_sc got=%h exp=7e", rd); end
    bus_read(SB, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_sb got=%h exp=00", rd); end
    checks++; if ({sout, sclk_out, sclk_oe, irq_serial} !== 4'b1100) begin
      failures++; $display("FAIL reset_outs got=%b exp=1100", {sout, sclk_out, sclk_oe, irq_serial});
    end
    bus_if.addr = 16'hFF03; #1;
    checks++; if ({bus_if.hit, bus_if.rdata} !== 9'h000) begin
      failures++; $display("FAIL miss_decode got=%h exp=000", {bus_if.hit, bus_if.rdata});
    end
    bus_if.addr = 16'h0000;
    rst = 1'b1;
    step();
  endtask

  task automatic test_int_transfer();
    logic [7:0] v, rd;
    logic prev, e, oe_bad;
    int irq_n, irq_t;
    v = 8'hA5; irq_n = 0; irq_t = -1; oe_bad = 1'b0;
    sin = 1'b1;
    bus_write(SB, v);
    for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
    prev = sclk_out;
    bus_write(SC, 8'h81);
    for (int t = 0; t <= 80; t++) begin
      if (t > 0) step();
      if (prev && !sclk_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL int_sout_extra t=%0d", t);
        end else begin
          e = exp_q.pop_front();
          if (sout !== e) begin failures++; $display("FAIL int_sout t=%0d got=%b exp=%b", t, sout, e); end
        end
      end
      prev = sclk_out;
      if (irq_serial) begin irq_n++; irq_t = t; end
      if (t < 60 && sclk_oe !== 1'b1) oe_bad = 1'b1;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL int_bits_missing got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    checks++; if (irq_n != 1) begin failures++; $display("FAIL int_irq_count got=%0d exp=1", irq_n); end
    checks++; if (irq_t != 60) begin failures++; $display("FAIL int_irq_latency got=%0d exp=60", irq_t); end
    checks++; if (oe_bad !== 1'b0) begin failures++; $display("FAIL int_sclk_oe got=0 exp=1"); end
    bus_read(SB, rd);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL int_sb got=%h exp=ff", rd); end
    bus_read(SC, rd);
    checks++; if (rd !== 8'h7F) begin failures++; $display("FAIL int_sc got=%h exp=7f", rd); end
    checks++; if ({sout, sclk_out, sclk_oe} !== 3'b110) begin
      failures++; $display("FAIL int_idle_outs got=%b exp=110", {sout, sclk_out, sclk_oe});
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    int irq_n;
    irq_n = 0;
    bus_write(SB, 8'hA5);
    bus_write(SC, 8'h81);
    repeat (20) step();
    bus_read(SC, rd);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL abort_sc_active got=%h exp=ff", rd); end
    bus_write(SC, 8'h01);
    checks++; if ({sout, sclk_out, sclk_oe} !== 3'b110) begin
      failures++; $display("FAIL abort_outs got=%b exp=110", {sout, sclk_out, sclk_oe});
    end
    for (int t = 0; t < 100; t++) begin
      step();
      if (irq_serial) irq_n++;
    end
    checks++; if (irq_n != 0) begin failures++; $display("FAIL abort_irq got=%0d exp=0", irq_n); end
    bus_read(SC, rd);
    checks++; if (rd !== 8'h7F) begin failures++; $display("FAIL abort_sc got=%h exp=7f", rd); end
  endtask

  task automatic test_ext_transfer();
    logic [7:0] v, pat, rd;
    logic e, oe_bad;
    int irq_n;
    v = 8'h3C; pat = 8'hC3; irq_n = 0; oe_bad = 1'b0;
    sclk_in = 1'b1;
    bus_write(SB, v);
    for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
    bus_write(SC, 8'h80);
    for (int b = 0; b < 8; b++) begin
      sclk_in = 1'b0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (irq_serial) irq_n++;
        if (sclk_oe !== 1'b0) oe_bad = 1'b1;
      end
      e = exp_q.pop_front();
      checks++; if (sout !== e) begin failures++; $display("FAIL ext_sout bit=%0d got=%b exp=%b", b, sout, e); end
      sin = pat[7-b];
      sclk_in = 1'b1;
      for (int c = 0; c < 5; c++) begin
        step();
        if (irq_serial) irq_n++;
        if (sclk_oe !== 1'b0) oe_bad = 1'b1;
      end
    end
    for (int c = 0; c < 10; c++) begin
      step();
      if (irq_serial) irq_n++;
    end
    checks++; if (irq_n != 1) begin failures++; $display("FAIL ext_irq_count got=%0d exp=1", irq_n); end
    checks++; if (oe_bad !== 1'b0) begin failures++; $display("FAIL ext_sclk_oe got=1 exp=0"); end
    bus_read(SB, rd);
    checks++; if (rd !== pat) begin failures++; $display("FAIL ext_sb got=%h exp=%h", rd, pat); end
    checks++; if (sout !== 1'b1) begin failures++; $display("FAIL ext_sout_idle got=%b exp=1", sout); end
    sin = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    int irq_n;
    irq_n = 0;
    bus_write(SB, 8'hA5);
    bus_write(SC, 8'h81);
    repeat (30) step();
    rst = 1'b0;
    #1;
    checks++; if ({sout, sclk_out, sclk_oe, irq_serial} !== 4'b1100) begin
      failures++; $display("FAIL rstmid_outs got=%b exp=1100", {sout, sclk_out, sclk_oe, irq_serial});
    end
    bus_read(SC, rd);
    checks++; if (rd !== 8'h7E) begin failures++; $display("FAIL rstmid_sc got=%h exp=7e", rd); end
    step(); step();
    rst = 1'b1;
    for (int t = 0; t < 100; t++) begin
      step();
      if (irq_serial) irq_n++;
    end
    checks++; if (irq_n != 0) begin failures++; $display("FAIL rstmid_irq got=%0d exp=0", irq_n); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int irq_n, irq_t;
    irq_n = 0; irq_t = -1;
    sin = 1'b1;
    bus_write(SB, 8'hA5);
    bus_write(SC, 8'h81);
    repeat (59) step();
    bus_write(SC, 8'h81);
    checks++; if (irq_serial !== 1'b1) begin failures++; $display("FAIL b2b_irq_on_done got=%b exp=1", irq_serial); end
    bus_read(SC, rd);
    checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL b2b_sc got=%h exp=ff", rd); end
    for (int t = 1; t <= 70; t++) begin
      step();
      if (irq_serial) begin irq_n++; irq_t = t; end
    end
    checks++; if (irq_n != 1) begin failures++; $display("FAIL b2b_irq_count got=%0d exp=1", irq_n); end
    checks++; if (irq_t != 60) begin failures++; $display("FAIL b2b_irq_latency got=%0d exp=60", irq_t); end
  endtask

  initial begin
    test_reset();
    test_int_transfer();
    test_abort();
    test_ext_transfer();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
